// File: rtl/seven_seg_scanner.sv
// Four-digit multiplexed hex display scanner. Loads are staged in a pending
// register and only reach the display at a frame wrap, so a frame never tears.
module seven_seg_scanner #(
  parameter int unsigned CLK_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value_i,
  input  logic        load_i,
  input  logic        blank_lz_i,
  input  logic [3:0]  dp_in_i,
  output logic [3:0]  hex_o,
  output logic [3:0]  digit_en_o,
  output logic        blank_o,
  output logic        dp_o,
  output logic        frame_done_o
);

  localparam int unsigned     CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0]   LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   disp_q, disp_d;
  logic [15:0]   pend_q, pend_d;
  logic          pend_v_q, pend_v_d;
  logic          frame_done_q;
  logic          tick_s;
  logic          wrap_s;
  logic          lz_s;

  assign tick_s = (presc_q == LAST);
  assign wrap_s = tick_s && (idx_q == 2'd3);

  // Next-state for prescaler, digit index and the display/pending pair.
  always_comb begin
    presc_d  = tick_s ? '0 : presc_q + CW'(1);
    idx_d    = tick_s ? idx_q + 2'd1 : idx_q;
    disp_d   = disp_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    if (wrap_s) begin
      // A load landing on the wrap itself bypasses (and discards) any staged value.
      pend_v_d = 1'b0;
      if (load_i) begin
        disp_d = value_i;
      end else if (pend_v_q) begin
        disp_d = pend_q;
      end else begin
        disp_d = disp_q;
      end
    end else if (load_i) begin
      pend_d   = value_i;
      pend_v_d = 1'b1;
    end else begin
      pend_d   = pend_q;
      pend_v_d = pend_v_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q      <= '0;
      idx_q        <= 2'd0;
      disp_q       <= 16'h0000;
      pend_q       <= 16'h0000;
      pend_v_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pend_v_q     <= pend_v_d;
      frame_done_q <= wrap_s;
    end
  end

  // Digit decode from registered index and display value only.
  always_comb begin
    case (idx_q)
      2'd0: begin
        hex_o      = disp_q[3:0];
        digit_en_o = 4'b0001;
        lz_s       = 1'b0;
      end
      2'd1: begin
        hex_o      = disp_q[7:4];
        digit_en_o = 4'b0010;
        lz_s       = (disp_q[15:4] == 12'h000);
      end
      2'd2: begin
        hex_o      = disp_q[11:8];
        digit_en_o = 4'b0100;
        lz_s       = (disp_q[15:8] == 8'h00);
      end
      2'd3: begin
        hex_o      = disp_q[15:12];
        digit_en_o = 4'b1000;
        lz_s       = (disp_q[15:12] == 4'h0);
      end
      default: begin
        hex_o      = 4'h0;
        digit_en_o = 4'b0001;
        lz_s       = 1'b0;
      end
    endcase
  end

  assign blank_o      = blank_lz_i & lz_s;
  assign dp_o         = dp_in_i[idx_q];
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Randomised self-checking bench for seven_seg_scanner; two instances
// (CLK_DIV=4 and CLK_DIV=1) share stimulus and are compared to a frame-level model.
module tb_seven_seg_scanner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = 16'h0000;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [3:0]  dp_in = 4'b0000;

  logic [3:0] d4_hex, d4_en, d1_hex, d1_en;
  logic       d4_bl, d4_dp, d4_fd, d1_bl, d1_dp, d1_fd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seven_seg_scanner #(.CLK_DIV(4)) u_div4 (
    .clk(clk), .rst_n(rst_n), .value_i(value), .load_i(load), .blank_lz_i(blank_lz),
    .dp_in_i(dp_in), .hex_o(d4_hex), .digit_en_o(d4_en), .blank_o(d4_bl), .dp_o(d4_dp),
    .frame_done_o(d4_fd)
  );

  seven_seg_scanner #(.CLK_DIV(1)) u_div1 (
    .clk(clk), .rst_n(rst_n), .value_i(value), .load_i(load), .blank_lz_i(blank_lz),
    .dp_in_i(dp_in), .hex_o(d1_hex), .digit_en_o(d1_en), .blank_o(d1_bl), .dp_o(d1_dp),
    .frame_done_o(d1_fd)
  );

  // Reference model: time since reset decides the digit; the display only
  // picks up the latest staged value when a frame of 4*div cycles ends.
  int          div_tab [2] = '{4, 1};
  int          m_t     [2];
  logic [15:0] m_disp  [2];
  logic [15:0] m_pend  [2];
  logic        m_pv    [2];
  logic        m_fd    [2];

  function automatic logic is_wrap(input int k);
    return (m_t[k] % (4 * div_tab[k])) == (4 * div_tab[k] - 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_t[k] <= 0; m_disp[k] <= 16'h0000; m_pend[k] <= 16'h0000;
        m_pv[k] <= 1'b0; m_fd[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_fd[k] <= is_wrap(k);
        m_t[k]  <= m_t[k] + 1;
        if (is_wrap(k)) begin
          m_pv[k] <= 1'b0;
          if (load) m_disp[k] <= value;
          else if (m_pv[k]) m_disp[k] <= m_pend[k];
        end else if (load) begin
          m_pend[k] <= value;
          m_pv[k]   <= 1'b1;
        end
      end
    end
  end

  // Expected {frame_done, dp, blank, digit_en, hex} for instance k.
  function automatic logic [10:0] exp_out(input int k);
    int i;
    logic [15:0] sh;
    logic bl;
    i  = (m_t[k] / div_tab[k]) % 4;
    sh = m_disp[k] >> (4 * i);
    bl = blank_lz && (i != 0) && (sh == 16'h0000);
    return {m_fd[k], dp_in[i], bl, 4'b0001 << i, sh[3:0]};
  endfunction

  function automatic logic [10:0] act_out(input int k);
    if (k == 0) return {d4_fd, d4_dp, d4_bl, d4_en, d4_hex};
    return {d1_fd, d1_dp, d1_bl, d1_en, d1_hex};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; value = 16'h0000; load = 1'b0; blank_lz = 1'b1; dp_in = 4'b0000;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (act_out(k) !== 11'b000_0001_0000) begin
        errors++; $display("FAIL reset dut%0d got %b expected %b", k, act_out(k), 11'b000_0001_0000);
      end
    end
    dp_in = 4'b0001; #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (act_out(k) !== 11'b010_0001_0000) begin
        errors++; $display("FAIL reset_dp dut%0d got %b expected %b", k, act_out(k), 11'b010_0001_0000);
      end
    end
    dp_in = 4'b0000; rst_n = 1'b1; #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (act_out(k) !== 11'b000_0001_0000) begin
        errors++; $display("FAIL reset_release dut%0d got %b expected %b", k, act_out(k), 11'b000_0001_0000);
      end
    end
  endtask

  task automatic test_scan();
    int fd4 = 0;
    int fd1 = 0;
    blank_lz = 1'b0;
    for (int c = 0; c < 48; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (act_out(k) !== exp_out(k)) begin
          errors++; $display("FAIL scan dut%0d t=%0d got %b expected %b", k, m_t[k], act_out(k), exp_out(k));
        end
      end
      fd4 += int'(d4_fd);
      fd1 += int'(d1_fd);
    end
    checks++;
    if (fd4 !== 3) begin errors++; $display("FAIL scan_fd_div4 got %0d expected 3", fd4); end
    checks++;
    if (fd1 !== 12) begin errors++; $display("FAIL scan_fd_div1 got %0d expected 12", fd1); end
  endtask

  task automatic test_deferred_load();
    int t_load = -1;
    int t_new = -1;
    logic [3:0] exp_n [4] = '{4'hF, 4'h2, 4'hA, 4'h1};
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (act_out(k) !== exp_out(k)) begin
          errors++; $display("FAIL deferred dut%0d t=%0d got %b expected %b", k, m_t[k], act_out(k), exp_out(k));
        end
      end
      if (t_load >= 0 && m_t[0] > t_load && m_t[0] < t_new) begin
        checks++;
        if (d4_hex !== 4'h0) begin errors++; $display("FAIL deferred_old t=%0d got %h expected 0", m_t[0], d4_hex); end
      end
      if (t_new >= 0 && m_t[0] >= t_new && m_t[0] < t_new + 16) begin
        checks++;
        if (d4_hex !== exp_n[(m_t[0] - t_new) / 4]) begin
          errors++; $display("FAIL deferred_new t=%0d got %h expected %h", m_t[0], d4_hex, exp_n[(m_t[0] - t_new) / 4]);
        end
      end
      load = 1'b0;
      if (t_load < 0 && (m_t[0] % 16) == 5) begin
        value = 16'h1A2F; load = 1'b1; t_load = m_t[0]; t_new = (m_t[0] / 16 + 1) * 16;
      end
    end
  endtask

  task automatic test_last_load_wins();
    int stage = 0;
    int t_new = -1;
    for (int c = 0; c < 72; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (act_out(k) !== exp_out(k)) begin
          errors++; $display("FAIL lastload dut%0d t=%0d got %b expected %b", k, m_t[k], act_out(k), exp_out(k));
        end
      end
      if (t_new >= 0 && m_t[0] >= t_new) begin
        checks++;
        if (d4_hex !== 4'h2) begin errors++; $display("FAIL lastload_digit t=%0d got %h expected 2", m_t[0], d4_hex); end
      end
      load = 1'b0;
      if (stage == 0 && (m_t[0] % 16) == 2) begin
        value = 16'h1111; load = 1'b1; stage = 1;
      end else if (stage == 1 && (m_t[0] % 16) == 9) begin
        value = 16'h2222; load = 1'b1; stage = 2; t_new = (m_t[0] / 16 + 1) * 16;
      end
    end
  endtask

  task automatic test_wrap_load();
    int stage = 0;
    int t_new = -1;
    int i;
    logic [15:0] pat = 16'h00F0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (act_out(k) !== exp_out(k)) begin
          errors++; $display("FAIL wrapload dut%0d t=%0d got %b expected %b", k, m_t[k], act_out(k), exp_out(k));
        end
      end
      if (t_new >= 0 && m_t[0] >= t_new && m_t[0] < t_new + 32) begin
        i = ((m_t[0] - t_new) / 4) % 4;
        checks++;
        if (d4_hex !== pat[4*i +: 4]) begin
          errors++; $display("FAIL wrapload_digit t=%0d got %h expected %h", m_t[0], d4_hex, pat[4*i +: 4]);
        end
      end
      load = 1'b0;
      if (stage == 0 && (m_t[0] % 16) == 3) begin
        value = 16'h1234; load = 1'b1; stage = 1;
      end else if (stage == 1 && (m_t[0] % 16) == 15) begin
        value = 16'h00F0; load = 1'b1; stage = 2; t_new = m_t[0] + 1;
      end
    end
  endtask

  task automatic test_blanking();
    int s = -1;
    int f;
    int i;
    blank_lz = 1'b1;
    for (int c = 0; c < 96; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (act_out(k) !== exp_out(k)) begin
          errors++; $display("FAIL blanking dut%0d t=%0d got %b expected %b", k, m_t[k], act_out(k), exp_out(k));
        end
      end
      if (s >= 0) begin
        f = (m_t[0] - s) / 16;
        i = ((m_t[0] - s) % 16) / 4;
        if (f == 1 || f == 3) begin
          checks++;
          if (d4_bl !== (i != 0)) begin errors++; $display("FAIL blank_lz_on f=%0d digit=%0d got %b expected %b", f, i, d4_bl, (i != 0)); end
          checks++;
          if (d4_hex !== ((f == 1 && i == 0) ? 4'h5 : 4'h0)) begin errors++; $display("FAIL blank_hex f=%0d digit=%0d got %h", f, i, d4_hex); end
        end else if (f == 2) begin
          checks++;
          if (d4_bl !== 1'b0) begin errors++; $display("FAIL blank_lz_off digit=%0d got %b expected 0", i, d4_bl); end
        end
      end
      load = 1'b0;
      dp_in = 4'($urandom);
      if (s < 0 && (m_t[0] % 16) == 0) begin
        s = m_t[0]; value = 16'h0005; load = 1'b1;
      end else if (s >= 0 && m_t[0] == s + 36) begin
        value = 16'h0000; load = 1'b1;
      end
      blank_lz = !(s >= 0 && ((m_t[0] + 1 - s) / 16) == 2);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (act_out(k) !== exp_out(k)) begin
          errors++; $display("FAIL random dut%0d t=%0d got %b expected %b", k, m_t[k], act_out(k), exp_out(k));
        end
      end
      load = ($urandom_range(0, 5) == 0);
      value = 16'($urandom);
      blank_lz = 1'($urandom);
      dp_in = 4'($urandom);
    end
  endtask

  task automatic test_reset_mid();
    load = 1'b0; dp_in = 4'b0000; blank_lz = 1'b1;
    for (int c = 0; c < 32 && (m_t[0] % 16) != 6; c++) @(negedge clk);
    value = 16'hBEEF; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (act_out(k) !== 11'b000_0001_0000) begin
        errors++; $display("FAIL async_reset dut%0d got %b expected %b", k, act_out(k), 11'b000_0001_0000);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (act_out(k) !== exp_out(k)) begin
          errors++; $display("FAIL post_reset dut%0d t=%0d got %b expected %b", k, m_t[k], act_out(k), exp_out(k));
        end
      end
      checks++;
      if (d4_hex !== 4'h0 || d1_hex !== 4'h0) begin
        errors++; $display("FAIL pend_discard t=%0d got %h/%h expected 0/0", m_t[0], d4_hex, d1_hex);
      end
      if (c < 4) begin
        checks++;
        if (d4_en !== ((c < 3) ? 4'b0001 : 4'b0010)) begin
          errors++; $display("FAIL full_count c=%0d got %b", c, d4_en);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_deferred_load();
    test_last_load_wins();
    test_wrap_load();
    test_blanking();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_seg_scanner.md
SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 Parameter: CLK_DIV, default 50000, clock cycles each digit is shown; legal range 1..2^20.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 value  input  16  four hex digits; value[3:0] is digit 0 (rightmost), value[15:12] is digit 3.
REQ-005 load  input  1  single-cycle strobe; captures value for display at next frame boundary.
REQ-006 blank_lz  input  1  enables leading-zero blanking when high.
REQ-007 dp_in  input  4  decimal-point request per digit, bit i for digit i.
REQ-008 hex  output  4  nibble of the currently selected digit; feeds the hex-to-7-segment converter.
REQ-009 digit_en  output  4  one-hot active-high digit select, bit i selects digit i.
REQ-010 blank  output  1  high when the selected digit is to be dark; downstream forces all segments off.
REQ-011 dp  output  1  dp_in bit of the selected digit.
REQ-012 frame_done  output  1  one-cycle pulse at every frame wrap (digit 3 -> digit 0).

Function
REQ-013 Prescaler SHALL count 0..CLK_DIV-1 and wrap; tick SHALL be asserted in the cycle the count equals CLK_DIV-1.
REQ-014 With CLK_DIV=1, tick SHALL be asserted every cycle.
REQ-015 Digit index idx (2 bits) SHALL increment on each tick, wrapping 3 -> 0; no other event changes idx.
REQ-016 digit_en SHALL equal one-hot(idx), derived from registered idx only; exactly one bit high at all times, including reset.
REQ-017 Internal registers: disp (16 b, shown value), pend (16 b), pend_v (1 b).
REQ-018 load with no wrap tick in the same cycle: pend <= value, pend_v <= 1; a later load before the wrap overwrites pend (last load wins).
REQ-019 Wrap tick (tick while idx==3) without load: if pend_v, disp <= pend and pend_v <= 0; otherwise disp unchanged.
REQ-020 Wrap tick with load in the same cycle: disp <= value directly, pend_v <= 0; any older pend is discarded.
REQ-021 disp SHALL change only on wrap ticks, so a frame never mixes old and new digits.
REQ-022 frame_done SHALL be registered and high exactly the cycle after each wrap tick, i.e. the first cycle idx==0.
REQ-023 hex SHALL equal disp[4*idx+3 : 4*idx]; dp SHALL equal dp_in[idx] (combinational from dp_in).
REQ-024 blank SHALL be high iff blank_lz==1, idx!=0, and all disp nibbles from idx up to 3 are zero; digit 0 is never blanked.
REQ-025 blank_lz and dp_in SHALL take effect immediately (no frame synchronisation).
REQ-026 hex, digit_en and blank SHALL be functions of registered state only (no combinational path from value or load).

Reset
REQ-027 While rst_n==0: prescaler=0, idx=0, disp=0, pend=0, pend_v=0, frame_done=0; hence digit_en=4'b0001, hex=0, blank=0.
REQ-028 Reset asserted mid-frame or with pend_v set SHALL discard pend and restart at digit 0 with the full CLK_DIV count on the first cycle after release.

Verification (CLK_DIV=4 unless stated)
REQ-029 Release reset, no load -> digit_en 0001,0010,0100,1000 each held 4 cycles, repeating; hex=0; frame_done pulses every 16 cycles.
REQ-030 load value=16'h1A2F at digit 1 -> digits show F,2,A,1 only from the frame after the next wrap; the current frame still shows 0.
REQ-031 Two loads (16'h1111, then 16'h2222) in one frame -> next frame shows 2222; 1111 never displayed.
REQ-032 load 16'h00F0 coincident with wrap tick -> the immediately following frame shows 00F0; pend_v=0 afterwards.
REQ-033 disp=16'h0005, blank_lz=1 -> blank high on digits 3,2,1, low on digit 0 (hex=5); blank_lz=0 -> blank never high; disp=16'h0000 -> only digit 0 lit.
REQ-034 CLK_DIV=1: digit_en rotates every cycle, frame_done every 4 cycles; rst_n pulsed low mid-frame with pend_v=1 -> outputs return to reset values asynchronously, pend discarded.
